// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package rv_fetch_pkg;

  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries between fetch and decode.
// Flush wins over push/pop; push+pop together is legal when full.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || i_pop) && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is reset only because the head drives outputs that must read
  // zero out of reset; a deep FIFO would leave its RAM unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, zero-latency imem interface, fetch queue toward decode,
// execute redirects and a debug halt.
module instruction_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

  fetch_state_t  r_state;
  logic [31:0]   r_pc;
  logic          r_fault;
  logic          r_halted;
  logic [31:0]   r_fetch_count;

  fetch_state_t  w_state_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  assign imem_addr = r_pc;
  assign w_entry   = '{pc: r_pc, inst: imem_inst, fault: r_fault};
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves one unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      FS_RUN: begin
        if (halt_req) w_state_nxt = FS_HALT;
        else          w_push      = !redirect_valid && (!w_full || w_pop);
      end
      FS_HALT: begin
        if (!halt_req) w_state_nxt = FS_RUN;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = '0;
    if (!redirect_valid) w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FS_RUN;
      r_pc     <= RESET_PC;
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == FS_HALT) && (w_count_nxt == '0);
      if (redirect_valid) begin
        r_pc    <= {redirect_pc[31:2], 2'b00};
        r_fault <= |redirect_pc[1:0];
      end else if (w_push) begin
        r_pc    <= r_pc + 32'(INST_BYTES);
        r_fault <= 1'b0;
      end
    end
  end

  // A pop coinciding with a redirect was still delivered to decode, so it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_fetch_count <= '0;
    else if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_count (w_count),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_pc      = w_head.pc;
  assign out_inst    = w_head.inst;
  assign out_fault   = w_head.fault;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scenario bench for instruction_fetch: a scoreboard of expected decode
// hand-offs plus inline checks of timing, halt and reset behaviour.
module tb_instruction_fetch;
  import rv_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;
  fetch_entry_t q_exp[$];

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .fetch_count    (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: NOPs at words 0..3, an address-derived pattern elsewhere.
  function automatic logic [31:0] imem_model(input logic [31:0] a);
    if (a < 32'd16) return 32'h0000_0013;
    return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction

  assign imem_inst = imem_model(imem_addr);

  task automatic expect_entry(input logic [31:0] pc, input logic fault);
    fetch_entry_t e;
    e.pc    = pc;
    e.inst  = imem_model(pc);
    e.fault = fault;
    q_exp.push_back(e);
  endtask

  // One clock: scoreboard any hand-off at the coming edge, then return #1 after it.
  task automatic step();
    fetch_entry_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (q_exp.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, required no entry", out_pc, out_inst);
      end else begin
        e = q_exp.pop_front();
        if ({out_pc, out_inst, out_fault} !== e) begin
          bad++;
          $display("FAIL pop_entry: got pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b",
                   out_pc, out_inst, out_fault, e.pc, e.inst, e.fault);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    total++; if (out_pc !== 32'h0)     begin bad++; $display("FAIL rst_pc: got %h, required 0", out_pc); end
    total++; if (out_inst !== 32'h0)   begin bad++; $display("FAIL rst_inst: got %h, required 0", out_inst); end
    total++; if (out_fault !== 1'b0)   begin bad++; $display("FAIL rst_fault: got %b, required 0", out_fault); end
    total++; if (halted !== 1'b0)      begin bad++; $display("FAIL rst_halted: got %b, required 0", halted); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst_count: got %0d, required 0", fetch_count); end
    total++; if (imem_addr !== 32'h0)  begin bad++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    rst_n     = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_pre_valid: got %b, required 0", out_valid); end
    for (int i = 0; i < 4; i++) expect_entry(32'(4 * i), 1'b0);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_first_valid: got %b, required 1", out_valid); end
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL stream_count: got %0d, required 4", fetch_count); end
    total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL stream_addr: got %h, required 14", imem_addr); end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_stall_addr: got %h, required 8", imem_addr); end
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      bad++; $display("FAIL bp_head: got valid=%b pc=%h, required valid=1 pc=0", out_valid, out_pc);
    end
    expect_entry(32'h0, 1'b0);
    expect_entry(32'h4, 1'b0);
    expect_entry(32'h8, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL bp_count: got %0d, required 3", fetch_count); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got valid=%b, required 0", out_valid); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr: got %h, required 100", imem_addr); end
    expect_entry(32'h100, 1'b0);
    expect_entry(32'h104, 1'b0);
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      bad++; $display("FAIL redir_head: got valid=%b pc=%h, required valid=1 pc=100", out_valid, out_pc);
    end
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_fault();
    // Head 0x108 is popped in the redirect cycle and must still be counted.
    expect_entry(32'h108, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL fault_addr: got %h, required 100", imem_addr); end
    expect_entry(32'h100, 1'b1);
    expect_entry(32'h104, 1'b0);
    step();
    total++; if (out_fault !== 1'b1) begin bad++; $display("FAIL fault_flag: got %b, required 1", out_fault); end
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL fault_count: got %0d, required 8", fetch_count); end
  endtask

  task automatic test_halt();
    step();
    expect_entry(32'h108, 1'b0);
    expect_entry(32'h10C, 1'b0);
    halt_req  = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_draining: got %b, required 0", halted); end
    step();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set: got %b, required 1", halted); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_empty: got %b, required 0", out_valid); end
    total++; if (imem_addr !== 32'h110) begin bad++; $display("FAIL halt_addr: got %h, required 110", imem_addr); end
    step();
    total++; if (halted !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL halt_hold: got halted=%b valid=%b, required 1 0", halted, out_valid);
    end
    halt_req = 1'b0;
    step();
    total++; if (halted !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL halt_release: got halted=%b valid=%b, required 0 0", halted, out_valid);
    end
    expect_entry(32'h110, 1'b0);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL halt_resume: got %b, required 1", out_valid); end
    step();
    out_ready = 1'b0;
    total++; if (fetch_count !== 32'd11) begin bad++; $display("FAIL halt_count: got %0d, required 11", fetch_count); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    expect_entry(32'hFFFF_FFF8, 1'b0);
    expect_entry(32'hFFFF_FFFC, 1'b0);
    expect_entry(32'h0000_0000, 1'b0);
    expect_entry(32'h0000_0004, 1'b0);
    step();
    step();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h, required 0", imem_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    total++; if (fetch_count !== 32'd15) begin bad++; $display("FAIL wrap_count: got %0d, required 15", fetch_count); end
  endtask

  task automatic test_async_reset();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid: got %b, required 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b, required 0", out_valid); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL areset_count: got %0d, required 0", fetch_count); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL areset_addr: got %h, required 0", imem_addr); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      bad++; $display("FAIL areset_restart: got valid=%b pc=%h, required valid=1 pc=0", out_valid, out_pc);
    end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL areset_next_addr: got %h, required 4", imem_addr); end
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt();
    test_wrap();
    test_async_reset();
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
